// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
//   md_op_t : operation code driven by the MDU control decoder (4 bits)
//   md_state_t : IDLE/BUSY state of the latency sequencer
//   is_md_start(op) : 1 for ops that launch a multi-cycle operation
//   Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU)
package mdu_pkg;

  localparam int MD_OP_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_t;

  typedef enum logic {
    MDS_IDLE = 1'b0,
    MDS_BUSY = 1'b1
  } md_state_t;

  function automatic logic is_md_start(input md_op_t op);
    logic r;
    r = 1'b0;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_latency_cnt.sv
// Latency sequencer for the MDU: counts the fixed busy window and pulses commit on its last edge.
//   Latency: commit on the edge ending cycle T+lat-1 when started in cycle T.
//   Backpressure: none; start is only honoured in IDLE, cancel aborts to IDLE without commit.
// Ports: clk, reset (async, active-high), start, cancel, lat (latency of the op being started),
//        busy_st (state==BUSY), commit (combinational, valid in the cycle before the committing edge).
module mdu_latency_cnt
  import mdu_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          cancel,
  input  logic [CW-1:0] lat,
  output logic          busy_st,
  output logic          commit
);

  md_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MDS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (cancel) begin
      state_d = MDS_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MDS_IDLE: begin
          if (start) begin
            // Single-cycle latency commits straight from IDLE.
            if (lat == CW'(1)) begin
              commit = 1'b1;
            end else begin
              state_d = MDS_BUSY;
              cnt_d   = lat - CW'(1);
            end
          end
        end
        MDS_BUSY: begin
          if (cnt_q == CW'(1)) begin
            commit  = 1'b1;
            state_d = MDS_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = MDS_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign busy_st = (state_q == MDS_BUSY);

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning HI/LO; MULT/DIV family plus MFHI/MFLO/MTHI/MTLO.
//   Latency: MUL_LAT / DIV_LAT cycles of busy, result visible in HI/LO the cycle after busy drops.
//   Backpressure: busy asks the stall unit to hold D; ops arriving while busy are ignored.
// Ports: clk, reset (async, active-high), op (md_op_t), rs/rt (forwarded operands), cancel (flush),
//        busy (start | BUSY), hilo_out (HI for MFHI, LO for MFLO, else 0).
// Optional feature macro: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (accumulate into {HI,LO}).
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  md_op_t      op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hilo_out
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [31:0]   hi_q, lo_q;
  logic [63:0]   pending_q, pending_d;
  logic          busy_st, commit, start, is_div;
  logic [CW-1:0] lat;

  // Gated by reset so busy reads 0 while reset is held, whatever op shows.
  assign start  = is_md_start(op) & ~busy_st & ~cancel & ~reset;
  assign is_div = (op == MD_DIV) || (op == MD_DIVU);
  assign lat    = is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
  assign busy   = start | busy_st;

  mdu_latency_cnt #(.CW(CW)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .cancel  (cancel),
    .lat     (lat),
    .busy_st (busy_st),
    .commit  (commit)
  );

  // Products: sign-extend to 64 bits so the low 64 bits of the product are exact.
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // Signed division via magnitudes avoids the 0x80000000 / -1 overflow case:
  // |0x80000000| = 0x80000000 as unsigned, quotient sign positive -> 0x80000000, remainder 0.
  logic        sgn_div, rs_neg, rt_neg;
  logic [31:0] div_a, div_b, q_u, r_u, quo, rem;
  assign sgn_div = (op == MD_DIV);
  assign rs_neg  = sgn_div & rs[31];
  assign rt_neg  = sgn_div & rt[31];
  assign div_a   = rs_neg ? (32'd0 - rs) : rs;
  assign div_b   = rt_neg ? (32'd0 - rt) : rt;
  // Divisor forced non-zero; the rt==0 result is discarded below.
  assign q_u     = div_a / ((div_b == 32'd0) ? 32'd1 : div_b);
  assign r_u     = div_a % ((div_b == 32'd0) ? 32'd1 : div_b);
  assign quo     = (rs_neg ^ rt_neg) ? (32'd0 - q_u) : q_u;
  assign rem     = rs_neg ? (32'd0 - r_u) : r_u;

  always_comb begin
    pending_d = pending_q;
    case (op)
      MD_MULT:  pending_d = prod_s;
      MD_MULTU: pending_d = prod_u;
      // Divide by zero commits the current HI/LO, leaving them unchanged.
      MD_DIV, MD_DIVU: pending_d = (rt == 32'd0) ? {hi_q, lo_q} : {rem, quo};
`ifdef MDU_MADD_EN
      MD_MADD:  pending_d = {hi_q, lo_q} + prod_s;
      MD_MADDU: pending_d = {hi_q, lo_q} + prod_u;
      MD_MSUB:  pending_d = {hi_q, lo_q} - prod_s;
      MD_MSUBU: pending_d = {hi_q, lo_q} - prod_u;
`endif
      default:  pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pending_q <= '0;
    end else begin
      if (start) pending_q <= pending_d;
      if (commit) begin
        // A commit coinciding with start only happens for latency 1.
        {hi_q, lo_q} <= start ? pending_d : pending_q;
      end else if (!busy_st && !cancel) begin
        if (op == MD_MTHI) hi_q <= rs;
        if (op == MD_MTLO) lo_q <= rs;
      end
    end
  end

  always_comb begin
    hilo_out = '0;
    if (op == MD_MFHI) hilo_out = hi_q;
    else if (op == MD_MFLO) hilo_out = lo_q;
  end

endmodule
